// File: rtl/yen_freq_meter.sv
// Gated-window rising-edge counter: synchronizes sig_in, counts rising edges over
// 2^(gate_sel+8) clock cycles and reports the result with valid/busy/ovf flags.
module yen_freq_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   edge_s;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   oflag_q, oflag_d;
  logic [14:0]            timer_q, timer_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != ACC_MAX)) return a + CNT_W'(1);
    return a;
  endfunction

  // Terminal timer value for a window of 2^(g+8) cycles.
  function automatic logic [14:0] win_last(input logic [2:0] g);
    logic [15:0] n;
    n = 16'd1 << ({1'b0, g} + 4'd8);
    return 15'(n - 16'd1);
  endfunction

  assign edge_s = sync_q[SYNC_STAGES-1] & ~s_d_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    oflag_d = oflag_q;
    timer_d = timer_q;
    count_d = count_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARM;
          acc_d   = '0;
          oflag_d = 1'b0;
          timer_d = win_last(gate_sel);
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ARM: state_d = GATE;
      GATE: begin
        acc_d   = sat_inc(acc_q, edge_s);
        oflag_d = oflag_q | (edge_s & (acc_q == ACC_MAX));
        timer_d = timer_q - 15'd1;
        // Result includes any edge seen in the final window cycle.
        if (timer_q == 15'd0) begin
          state_d = DONE;
          timer_d = '0;
          count_d = acc_d;
          ovf_d   = oflag_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      acc_q   <= '0;
      oflag_q <= 1'b0;
      timer_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q   <= sync_q[SYNC_STAGES-1];
      acc_q   <= acc_d;
      oflag_q <= oflag_d;
      timer_q <= timer_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_yen_freq_meter.sv
// Scoreboard bench for yen_freq_meter: directed windows with hand-computed counts,
// a default-width instance plus an 8-bit instance for saturation.
module tb_yen_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic [2:0]  gate_sel = 3'd0;
  logic [15:0] count;
  logic        valid, busy, ovf;
  logic [7:0]  count8;
  logic        valid8, busy8, ovf8;

  yen_freq_meter #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .gate_sel(gate_sel),
    .count(count), .valid(valid), .busy(busy), .ovf(ovf));

  yen_freq_meter #(.SYNC_STAGES(2), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start8), .gate_sel(gate_sel),
    .count(count8), .valid(valid8), .busy(busy8), .ovf(ovf8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Square wave on sig_in with half-period hp clocks (hp=0 holds low).
  int hp = 0;
  int ph = 0;
  always @(negedge clk) begin
    if (hp == 0) begin
      sig_in = 1'b0;
      ph = 0;
    end else begin
      ph = ph + 1;
      if (ph >= hp) begin
        ph = 0;
        sig_in = ~sig_in;
      end
    end
  end

  typedef struct {
    int cnt;
    int ovf;
    int vcyc;
    int blen;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitors: pop an expectation on each rising edge of valid.
  int brun = 0;
  int brun8 = 0;
  bit vp = 1'b0;
  bit vp8 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      brun = 0;
      vp = 1'b0;
    end else begin
      if (busy) brun++;
      if (valid && !vp) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL spurious_valid: got valid with empty scoreboard, count=%0d", count);
        end else begin
          e = q.pop_front();
          chk("count", int'(count), e.cnt);
          chk("ovf", int'(ovf), e.ovf);
          chk("valid_cycle", cyc, e.vcyc);
          chk("busy_len", brun, e.blen);
        end
        brun = 0;
      end
      vp = valid;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      brun8 = 0;
      vp8 = 1'b0;
    end else begin
      if (busy8) brun8++;
      if (valid8 && !vp8) begin
        if (q8.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL spurious_valid8: got valid with empty scoreboard, count=%0d", count8);
        end else begin
          e = q8.pop_front();
          chk("count8", int'(count8), e.cnt);
          chk("ovf8", int'(ovf8), e.ovf);
          chk("valid_cycle8", cyc, e.vcyc);
          chk("busy_len8", brun8, e.blen);
        end
        brun8 = 0;
      end
      vp8 = valid8;
    end
  end

  // One-cycle start pulse; E0 is the following posedge, valid visible N+2 negedges on.
  task automatic pulse(input bit use8, input int n, input int cnt, input int ov);
    exp_t e;
    @(negedge clk);
    if (use8) start8 = 1'b1; else start = 1'b1;
    e.cnt = cnt;
    e.ovf = ov;
    e.vcyc = cyc + n + 2;
    e.blen = n + 1;
    if (use8) q8.push_back(e); else q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: pending=%0d required 0", q.size() + q8.size());
      q.delete();
      q8.delete();
    end
  endtask

  task automatic settle(input int h);
    hp = h;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int c0;

    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_count8", int'(count8), 0);
    chk("rst_valid8", int'(valid8), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clk/8, N=256 -> 32 edges
    gate_sel = 3'd0;
    settle(4);
    pulse(1'b0, 256, 32, 0);
    drain(300);

    // Back-to-back with start held, clk/4 -> 64 every 258 cycles
    settle(2);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 3; k++) begin
      e.cnt = 64; e.ovf = 0; e.vcyc = c0 + 258 * k; e.blen = 257;
      q.push_back(e);
    end
    repeat (774) @(negedge clk);
    start = 1'b0;
    drain(10);
    repeat (3) @(negedge clk);
    chk("done_valid_hold", int'(valid), 1);

    // start while busy, gate_sel changed mid-window: single N=256 run, clk/8 -> 32
    settle(4);
    pulse(1'b0, 256, 32, 0);
    repeat (88) @(negedge clk);
    @(negedge clk);
    gate_sel = 3'd3;
    start = 1'b1;
    chk("hold_count_a", int'(count), 64);
    chk("busy_valid_low", int'(valid), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("hold_count_b", int'(count), 64);
    drain(400);
    repeat (5) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    gate_sel = 3'd0;

    // Reset mid-GATE, then a normal measurement
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    pulse(1'b0, 256, 32, 0);
    drain(300);

    // Saturation on 8-bit instance: clk/2, N=1024 -> 512 edges
    gate_sel = 3'd2;
    settle(1);
    pulse(1'b1, 1024, 255, 1);
    drain(1200);

    // Longest window: clk/2, N=32768 -> 16384
    gate_sel = 3'd7;
    settle(1);
    pulse(1'b0, 32768, 16384, 0);
    drain(33000);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
